// File: rtl/encoder_83_evq_pkg.sv
// Shared constants and priority helper for the 8-to-3 event encoder.
package encoder_83_evq_pkg;

  localparam bit PRIO_HI7_DEF = 1'b1;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } prio_t;

  // Later matches overwrite earlier ones, so scan order sets the winner.
  function automatic prio_t prio_idx(
    input logic [N_REQ-1:0] vec,
    input logic             hi7
  );
    prio_t r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = hi7 ? i : (N_REQ - 1 - i);
      if (vec[k]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder_83_evq_prio_enc_83.sv
// Combinational 8-to-3 priority encoder.
module prio_enc_83
  import encoder_83_evq_pkg::*;
#(
  parameter bit PRIO_HI7 = PRIO_HI7_DEF
) (
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  prio_t r;

  always_comb begin
    r     = prio_idx(vec, PRIO_HI7);
    idx   = r.idx;
    found = r.found;
  end

endmodule

// File: rtl/encoder_83_evq.sv
// Sequential 8-to-3 priority encoder: captures active-low events,
// issues the highest-priority pending index over valid/ready.
module encoder_83_evq
  import encoder_83_evq_pkg::*;
#(
  parameter bit PRIO_HI7 = PRIO_HI7_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req_n,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_code,
  output logic             gs,
  output logic [N_REQ-1:0] pend,
  output logic             ovf
);

  logic [N_REQ-1:0] req_d;
  logic [N_REQ-1:0] evt;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] pend_next;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic             load;

  prio_enc_83 #(
    .PRIO_HI7(PRIO_HI7)
  ) u_prio (
    .vec  (pend),
    .idx  (sel),
    .found(found)
  );

  always_comb begin
    evt       = req_d & ~req_n & {N_REQ{en}};
    load      = en & found & (~out_valid | out_ready);
    clr       = load ? (N_REQ'(1) << sel) : '0;
    // a fresh event on the issued bit re-pends it
    pend_next = evt | (pend & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_d     <= '1;
      pend      <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      gs        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      req_d <= req_n;
      pend  <= pend_next;
      gs    <= |pend_next;
      ovf   <= |(evt & pend & ~clr);
      if (load) begin
        out_valid <= 1'b1;
        out_code  <= sel;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder_83_evq.sv
// Directed self-checking bench for encoder_83_evq.
module tb_encoder_83_evq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req_n;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic       gs;
  logic [7:0] pend;
  logic       ovf;

  int n_chk = 0;
  int n_fail = 0;

  encoder_83_evq #(.PRIO_HI7(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req_n    (req_n),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_code (out_code),
    .gs       (gs),
    .pend     (pend),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req_n = 8'hFF; out_ready = 1'b1;
    tick(); tick();
    n_chk++;
    if ({out_valid, out_code, gs, pend, ovf} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b c=%0d gs=%b p=%h o=%b want 0",
               out_valid, out_code, gs, pend, ovf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req_n = 8'hFB;
    tick();
    n_chk++;
    if (pend !== 8'h04 || gs !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pend got p=%h gs=%b v=%b want 04 1 0",
               pend, gs, out_valid);
    end
    req_n = 8'hFF;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd2 || pend !== 8'h00 || gs !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue got v=%b c=%0d p=%h gs=%b want 1 2 00 0",
               out_valid, out_code, pend, gs);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || out_code !== 3'd2) begin
      n_fail++;
      $display("FAIL single_done got v=%b c=%0d want 0 2", out_valid, out_code);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req_n = 8'h5D;
    tick();
    n_chk++;
    if (pend !== 8'hA2) begin
      n_fail++;
      $display("FAIL multi_pend got %h want a2", pend);
    end
    req_n = 8'hFF;
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd7 || pend !== 8'h22) begin
      n_fail++;
      $display("FAIL multi_stall got v=%b c=%0d p=%h want 1 7 22",
               out_valid, out_code, pend);
    end
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd5) begin
      n_fail++;
      $display("FAIL multi_b2b5 got v=%b c=%0d want 1 5", out_valid, out_code);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd1 || pend !== 8'h00) begin
      n_fail++;
      $display("FAIL multi_b2b1 got v=%b c=%0d p=%h want 1 1 00",
               out_valid, out_code, pend);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_end got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    req_n = 8'hE7;
    tick();
    req_n = 8'hFF;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd4 || pend !== 8'h08) begin
      n_fail++;
      $display("FAIL ovf_setup got v=%b c=%0d p=%h want 1 4 08",
               out_valid, out_code, pend);
    end
    req_n = 8'hF7;
    tick();
    n_chk++;
    if (ovf !== 1'b1 || pend !== 8'h08) begin
      n_fail++;
      $display("FAIL ovf_pulse got o=%b p=%h want 1 08", ovf, pend);
    end
    req_n = 8'hFF;
    tick();
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got %b want 0", ovf);
    end
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd3 || pend !== 8'h00) begin
      n_fail++;
      $display("FAIL ovf_issue got v=%b c=%0d p=%h want 1 3 00",
               out_valid, out_code, pend);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_once got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_set_over_clear();
    out_ready = 1'b0;
    req_n = 8'h3F;
    tick();
    req_n = 8'hFF;
    tick();
    tick();
    n_chk++;
    if (out_code !== 3'd7 || pend !== 8'h40) begin
      n_fail++;
      $display("FAIL soc_setup got c=%0d p=%h want 7 40", out_code, pend);
    end
    out_ready = 1'b1;
    req_n = 8'hBF;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd6 || pend !== 8'h40 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL soc_repend got v=%b c=%0d p=%h o=%b want 1 6 40 0",
               out_valid, out_code, pend, ovf);
    end
    req_n = 8'hFF;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd6 || pend !== 8'h00) begin
      n_fail++;
      $display("FAIL soc_second got v=%b c=%0d p=%h want 1 6 00",
               out_valid, out_code, pend);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL soc_end got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_enable();
    out_ready = 1'b0;
    req_n = 8'hFD;
    tick();
    req_n = 8'hFF;
    tick();
    en = 1'b0;
    req_n = 8'hFE;
    tick();
    n_chk++;
    if (pend !== 8'h00 || out_valid !== 1'b1 || out_code !== 3'd1) begin
      n_fail++;
      $display("FAIL en_gate got p=%h v=%b c=%0d want 00 1 1",
               pend, out_valid, out_code);
    end
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drain got v=%b want 0", out_valid);
    end
    en = 1'b1;
    tick();
    tick();
    n_chk++;
    if (pend !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_stale got p=%h v=%b want 00 0", pend, out_valid);
    end
    req_n = 8'hFF;
    tick();
  endtask

  task automatic test_reset_behaviour();
    out_ready = 1'b0;
    req_n = 8'h7F;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if (pend !== 8'h80 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held got p=%h v=%b want 80 0", pend, out_valid);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_code !== 3'd7) begin
      n_fail++;
      $display("FAIL rst_issue got v=%b c=%0d want 1 7", out_valid, out_code);
    end
    req_n = 8'hEF;
    tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if ({out_valid, out_code, gs, pend, ovf} !== 14'd0) begin
      n_fail++;
      $display("FAIL rst_mid got v=%b c=%0d gs=%b p=%h o=%b want 0",
               out_valid, out_code, gs, pend, ovf);
    end
    rst = 1'b0;
    req_n = 8'hFF;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_set_over_clear();
    test_enable();
    test_reset_behaviour();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
